output_wrapper: RTL and testbench
=================================

OUTPUT_WRAPPER -- requirements
Module: output_wrapper

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst  input  1  asynchronous, active-low reset; clears all state when low.
REQ-003 SHALL have port: done  input  1  core result valid; the core holds it high until it sees core_ack.
REQ-004 SHALL have port: result  input  16  core result; sampled only in LOAD.
REQ-005 SHALL have port: data_accept  input  1  downstream receiver acknowledge for the current byte.
REQ-006 SHALL have port: core_ack  output  1  one-cycle pulse: result captured.
REQ-007 SHALL have port: dataout  output  1  a valid byte is on bus.
REQ-008 SHALL have port: bus  output  8  outgoing byte.
REQ-009 SHALL have port: busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement a Moore FSM with states IDLE, LOAD, SEND, RELEASE, FINISH; outputs SHALL depend on state and registers only.
REQ-011 IDLE: all outputs 0; done=1 -> LOAD, else stay in IDLE; data_accept SHALL be ignored.
REQ-012 LOAD (exactly one cycle): capture result into a 16-bit holding register, clear the byte index to 0, core_ack=1 -> SEND.
REQ-013 SEND: dataout=1, bus=byte[index]; data_accept=1 -> RELEASE, else stay in SEND for any number of cycles.
REQ-014 RELEASE: dataout=0, bus keeps the same byte; data_accept=0 -> (index==last ? FINISH : index+1, SEND), else stay in RELEASE.
REQ-015 Byte order: index 0 = holding[7:0], index 1 = holding[15:8]; last=1 (last=2 per REQ-024).
REQ-016 FINISH: outputs 0 except busy=1; done=0 -> IDLE; done=1 -> stay, so one result is never sent twice.
REQ-017 Handshake SHALL be full four-phase per byte; a byte SHALL take at least 2 cycles (SEND + RELEASE).
REQ-018 Minimum transaction latency, done rising to the first dataout: 2 cycles (IDLE->LOAD->SEND).
REQ-019 Changes on result after LOAD SHALL NOT affect transmitted bytes.
REQ-020 data_accept already high on entry to SEND SHALL be taken as acknowledge for that byte (next state RELEASE).
REQ-021 bus SHALL be 8'h00 in IDLE, LOAD and FINISH.

Reset
REQ-022 rst low SHALL force, without waiting for a clock edge: state=IDLE, index=0, holding=16'h0000, core_ack=0, dataout=0, busy=0, bus=8'h00.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer; after rst releases, a new done SHALL restart from byte 0 with fresh capture.

Configuration
REQ-024 Macro OUTPUT_WRAPPER_PARITY_EN defined: a third byte, holding[7:0] XOR holding[15:8], SHALL be sent at index 2 with the same handshake, and last=2.
REQ-025 OUTPUT_WRAPPER_PARITY_EN undefined: exactly two bytes SHALL be sent; no parity logic SHALL be present.

Verification
REQ-026 result=16'h3044, done pulse, prompt accepts -> bus 8'h44 then 8'h30, each under dataout, core_ack pulsed once; with PARITY_EN a third byte 8'h74.
REQ-027 data_accept withheld 10 cycles in SEND -> dataout and bus hold 8'h44 for all 10 cycles; data_accept held 5 cycles -> RELEASE holds 5 cycles, index not advanced.
REQ-028 done held high 20 cycles past the final byte -> stays in FINISH with busy=1, no second transfer; done low -> IDLE next cycle.
REQ-029 rst pulsed low while in SEND with index=1 -> outputs zero immediately; next done with result=16'hABCD -> 8'hCD sent first.
REQ-030 data_accept toggling in IDLE -> no outputs change; result changed to 16'hFFFF after LOAD -> original bytes still sent.

Source files
------------

// File: rtl/output_wrapper.sv
// Byte-serialising output stage: captures a 16-bit core result and sends it as bytes over a
// four-phase handshake. Define OUTPUT_WRAPPER_PARITY_EN to append an XOR parity byte.
module output_wrapper (
    input  logic        clk,
    input  logic        rst,
    input  logic        done,
    input  logic [15:0] result,
    input  logic        data_accept,
    output logic        core_ack,
    output logic        dataout,
    output logic [7:0]  bus,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        SEND    = 3'd2,
        RELEASE = 3'd3,
        FINISH  = 3'd4
    } state_t;

`ifdef OUTPUT_WRAPPER_PARITY_EN
    localparam logic [1:0] LAST_IDX = 2'd2;
`else
    localparam logic [1:0] LAST_IDX = 2'd1;
`endif

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  index_r;
    logic [1:0]  next_index_s;
    logic [15:0] holding_r;
    logic [15:0] next_holding_s;
    logic        core_ack_r;
    logic        dataout_r;
    logic        busy_r;
    logic [7:0]  bus_r;

    function automatic logic [7:0] byte_sel(input logic [15:0] h, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = h[7:0];
            2'd1:    b = h[15:8];
`ifdef OUTPUT_WRAPPER_PARITY_EN
            2'd2:    b = h[7:0] ^ h[15:8];
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Next-state, byte index and holding register logic.
    always_comb begin
        next_state_s   = state_r;
        next_index_s   = index_r;
        next_holding_s = holding_r;
        case (state_r)
            IDLE: begin
                if (done) next_state_s = LOAD;
                else      next_state_s = IDLE;
            end
            LOAD: begin
                next_holding_s = result;
                next_index_s   = 2'd0;
                next_state_s   = SEND;
            end
            SEND: begin
                if (data_accept) next_state_s = RELEASE;
                else             next_state_s = SEND;
            end
            RELEASE: begin
                if (!data_accept) begin
                    if (index_r == LAST_IDX) begin
                        next_state_s = FINISH;
                    end else begin
                        next_index_s = index_r + 2'd1;
                        next_state_s = SEND;
                    end
                end else begin
                    next_state_s = RELEASE;
                end
            end
            FINISH: begin
                // Stay until done drops so a held done never triggers a resend.
                if (!done) next_state_s = IDLE;
                else       next_state_s = FINISH;
            end
            default: begin
                next_state_s   = IDLE;
                next_index_s   = 2'd0;
                next_holding_s = 16'h0000;
            end
        endcase
    end

    // State registers plus outputs registered from the next state, keeping them Moore and glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            index_r    <= 2'd0;
            holding_r  <= 16'h0000;
            core_ack_r <= 1'b0;
            dataout_r  <= 1'b0;
            busy_r     <= 1'b0;
            bus_r      <= 8'h00;
        end else begin
            state_r    <= next_state_s;
            index_r    <= next_index_s;
            holding_r  <= next_holding_s;
            core_ack_r <= (next_state_s == LOAD);
            dataout_r  <= (next_state_s == SEND);
            busy_r     <= (next_state_s != IDLE);
            if ((next_state_s == SEND) || (next_state_s == RELEASE)) begin
                bus_r <= byte_sel(next_holding_s, next_index_s);
            end else begin
                bus_r <= 8'h00;
            end
        end
    end

    assign core_ack = core_ack_r;
    assign dataout  = dataout_r;
    assign busy     = busy_r;
    assign bus      = bus_r;

endmodule

// File: tb/tb_output_wrapper.sv
// Self-checking bench for output_wrapper: directed vector table, reset/corner sequences and random transfers.
module tb_output_wrapper;

`ifdef OUTPUT_WRAPPER_PARITY_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        done = 1'b0;
    logic [15:0] result = 16'h0000;
    logic        data_accept = 1'b0;
    logic        core_ack;
    logic        dataout;
    logic [7:0]  bus;
    logic        busy;

    int checks = 0;
    int failures = 0;

    output_wrapper dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .result      (result),
        .data_accept (data_accept),
        .core_ack    (core_ack),
        .dataout     (dataout),
        .bus         (bus),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] res;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  b2;
        int          send_wait;
        int          rel_hold;
        int          fin_hold;
        logic        early;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic ca, input logic dv, input logic bz, input logic [7:0] bs);
        checks++;
        if ({core_ack, dataout, busy, bus} !== {ca, dv, bz, bs}) begin
            failures++;
            $display("FAIL %s: got core_ack=%b dataout=%b busy=%b bus=%h, expected core_ack=%b dataout=%b busy=%b bus=%h",
                     name, core_ack, dataout, busy, bus, ca, dv, bz, bs);
        end
    endtask

    // Reference: bytes come straight from the captured value by arithmetic.
    function automatic logic [7:0] model_byte(input logic [15:0] r, input int k);
        int lo, hi;
        lo = int'(r) % 256;
        hi = int'(r) / 256;
        if (k == 0) return 8'(lo);
        if (k == 1) return 8'(hi);
        return 8'(lo ^ hi);
    endfunction

    // One full transfer from IDLE back to IDLE, checking every cycle.
    task automatic run_txn(input logic [15:0] res, input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                           input int sw, input int rh, input int fh, input logic early);
        logic [7:0] exp_b[3];
        exp_b[0] = e0;
        exp_b[1] = e1;
        exp_b[2] = e2;
        result = res;
        data_accept = early;
        done = 1'b1;
        tick();
        chk("load", 1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        chk("send_entry", 1'b0, 1'b1, 1'b1, exp_b[0]);
        result = 16'hFFFF;
        if (fh == 0) done = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (!(early && k == 0)) begin
                repeat (sw) begin
                    tick();
                    chk("send_wait", 1'b0, 1'b1, 1'b1, exp_b[k]);
                end
            end
            data_accept = 1'b1;
            tick();
            chk("release", 1'b0, 1'b0, 1'b1, exp_b[k]);
            repeat (rh) begin
                tick();
                chk("release_hold", 1'b0, 1'b0, 1'b1, exp_b[k]);
            end
            data_accept = 1'b0;
            tick();
            if (k < NB - 1) chk("send_next", 1'b0, 1'b1, 1'b1, exp_b[k + 1]);
            else            chk("finish", 1'b0, 1'b0, 1'b1, 8'h00);
        end
        repeat (fh) begin
            tick();
            chk("finish_hold", 1'b0, 1'b0, 1'b1, 8'h00);
        end
        done = 1'b0;
        tick();
        chk("idle_return", 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        vecs[0] = '{16'h3044, 8'h44, 8'h30, 8'h74, 0, 0, 0, 1'b0};
        vecs[1] = '{16'h3044, 8'h44, 8'h30, 8'h74, 10, 5, 0, 1'b0};
        vecs[2] = '{16'h3044, 8'h44, 8'h30, 8'h74, 0, 0, 20, 1'b0};
        vecs[3] = '{16'h0000, 8'h00, 8'h00, 8'h00, 1, 1, 1, 1'b0};
        vecs[4] = '{16'hFFFF, 8'hFF, 8'hFF, 8'h00, 2, 0, 0, 1'b0};
        vecs[5] = '{16'hA55A, 8'h5A, 8'hA5, 8'hFF, 0, 2, 3, 1'b0};
        vecs[6] = '{16'h8001, 8'h01, 8'h80, 8'h81, 3, 1, 0, 1'b0};
        vecs[7] = '{16'h1357, 8'h57, 8'h13, 8'h44, 0, 0, 0, 1'b1};

        #1;
        chk("reset_state", 1'b0, 1'b0, 1'b0, 8'h00);
        #3;
        rst = 1'b1;
        tick();
        chk("idle_after_reset", 1'b0, 1'b0, 1'b0, 8'h00);

        for (int i = 0; i < 6; i++) begin
            data_accept = ~data_accept;
            tick();
            chk("idle_accept_toggle", 1'b0, 1'b0, 1'b0, 8'h00);
        end
        data_accept = 1'b0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].res, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                    vecs[i].send_wait, vecs[i].rel_hold, vecs[i].fin_hold, vecs[i].early);
        end

        // Abort in SEND of byte 1, then a fresh transfer must start at byte 0.
        result = 16'h1234;
        done = 1'b1;
        tick();
        chk("abort_load", 1'b1, 1'b0, 1'b1, 8'h00);
        tick();
        done = 1'b0;
        data_accept = 1'b1;
        tick();
        data_accept = 1'b0;
        tick();
        chk("abort_send1", 1'b0, 1'b1, 1'b1, 8'h12);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_async_clear", 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        chk("abort_held", 1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        chk("abort_idle", 1'b0, 1'b0, 1'b0, 8'h00);
        run_txn(16'hABCD, 8'hCD, 8'hAB, 8'h66, 0, 0, 0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            logic [15:0] r;
            r = 16'($urandom);
            run_txn(r, model_byte(r, 0), model_byte(r, 1), model_byte(r, 2),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
